// File: rtl/eq_pkg.sv
// Shared constants and types for the stereo tap-data sample queue.
package eq_pkg;
    localparam int DEPTH = 1021;
    localparam int WIDTH = 16;
    localparam int AW    = 10;

    typedef logic signed [WIDTH-1:0] smpl_t;
    typedef logic [AW-1:0]           addr_t;

    typedef struct packed {
        smpl_t lft;
        smpl_t rght;
    } stereo_t;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, GAP} sq_state_t;

    localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);
    localparam addr_t FULL_CNT  = addr_t'(DEPTH);

    function automatic addr_t next_addr(input addr_t a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction
endpackage

// File: rtl/dp_ram.sv
// Simple dual-port sample RAM: one synchronous write port, one synchronous
// read port with 1-cycle latency and read-before-write on address collision.
module dp_ram
    import eq_pkg::*;
(
    input  logic    clk,
    input  logic    we,
    input  addr_t   waddr,
    input  stereo_t wdata,
    input  logic    re,
    input  addr_t   raddr,
    output stereo_t rdata
);
    localparam int WORDS = 2 ** AW;

    stereo_t mem [WORDS];

    // NOTE: the array has no reset so it maps onto block RAM; nothing reads a
    // slot before it has been written because bursts wait for a full buffer.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/sample_queue.sv
// Circular stereo sample buffer that replays the last DEPTH samples,
// oldest first, under a sequencing window on every new sample once full.
module sample_queue
    import eq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [WIDTH-1:0] lft_smpl,
    input  logic [WIDTH-1:0] rght_smpl,
    output logic             sequencing,
    output logic [WIDTH-1:0] lft_out,
    output logic [WIDTH-1:0] rght_out
);
    sq_state_t state;
    addr_t     wr_ptr;
    addr_t     rd_ptr;
    addr_t     rd_cnt;
    addr_t     fill_cnt;
    logic      pending;
    logic      rd_valid;

    addr_t     wr_ptr_inc;
    addr_t     fill_inc;
    logic      trigger;
    logic      rd_en;
    stereo_t   wdata;
    stereo_t   rdata;

    // NOTE: every signal gets a value on every pass, so no latch is inferred.
    always_comb begin
        wr_ptr_inc = next_addr(wr_ptr);
        fill_inc   = (fill_cnt == FULL_CNT) ? FULL_CNT : fill_cnt + 1'b1;
        trigger    = valid && (fill_inc == FULL_CNT);
        rd_en      = (state == READ);
        wdata.lft  = lft_smpl;
        wdata.rght = rght_smpl;
    end

    dp_ram u_ram (
        .clk   (clk),
        .we    (valid),
        .waddr (wr_ptr),
        .wdata (wdata),
        .re    (rd_en),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // NOTE: non-blocking assignments make every update here see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_cnt     <= '0;
            fill_cnt   <= '0;
            pending    <= 1'b0;
            rd_valid   <= 1'b0;
            sequencing <= 1'b0;
            lft_out    <= '0;
            rght_out   <= '0;
        end else begin
            if (valid) begin
                wr_ptr   <= wr_ptr_inc;
                fill_cnt <= fill_inc;
            end

            // Output stage trails the RAM read by one cycle and is zero outside a burst.
            rd_valid   <= rd_en;
            sequencing <= rd_valid;
            lft_out    <= rd_valid ? rdata.lft  : '0;
            rght_out   <= rd_valid ? rdata.rght : '0;

            case (state)
                IDLE: begin
                    if (trigger) begin
                        rd_ptr <= wr_ptr_inc;
                        rd_cnt <= '0;
                        state  <= READ;
                    end
                end
                READ: begin
                    rd_ptr <= next_addr(rd_ptr);
                    rd_cnt <= rd_cnt + 1'b1;
                    if (valid)
                        pending <= 1'b1;
                    if (rd_cnt == LAST_ADDR)
                        state <= DRAIN;
                end
                DRAIN: begin
                    pending <= 1'b0;
                    state   <= (pending || valid) ? GAP : IDLE;
                end
                GAP: begin
                    // A write landing on this edge is already the newest sample.
                    rd_ptr <= valid ? wr_ptr_inc : wr_ptr;
                    rd_cnt <= '0;
                    state  <= READ;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_queue.sv
// Randomized self-checking bench for sample_queue against a queue-based model.
module tb_sample_queue;
    import eq_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid;
    logic [WIDTH-1:0] lft_smpl;
    logic [WIDTH-1:0] rght_smpl;
    logic             sequencing;
    logic [WIDTH-1:0] lft_out;
    logic [WIDTH-1:0] rght_out;

    sample_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (valid),
        .lft_smpl   (lft_smpl),
        .rght_smpl  (rght_smpl),
        .sequencing (sequencing),
        .lft_out    (lft_out),
        .rght_out   (rght_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the last DEPTH samples, plus the expected output keyed by edge.
    stereo_t hist [$];
    stereo_t exp_map [int];
    int      edge_n      = 0;
    int      burst_trig  = -100000;
    int      follow_edge = -1;
    int      lax_until   = -1;
    int      seq_high    = 0;
    int      rise_edge   = -1;
    logic    prev_seq    = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic schedule(input int t);
        burst_trig  = t;
        follow_edge = -1;
        for (int k = 0; k < DEPTH; k++)
            exp_map[t + 2 + k] = hist[k];
    endtask

    task automatic model_write(input stereo_t s);
        hist.push_back(s);
        if (hist.size() > DEPTH)
            void'(hist.pop_front());
        if (edge_n > burst_trig && edge_n <= burst_trig + DEPTH + 1) begin
            if (follow_edge >= 0)
                lax_until = burst_trig + DEPTH + 1;
            follow_edge = burst_trig + DEPTH + 2;
        end else if (hist.size() == DEPTH) begin
            schedule(edge_n);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        exp_map.delete();
        burst_trig  = -100000;
        follow_edge = -1;
        lax_until   = -1;
    endtask

    task automatic compare();
        logic    exp_seq;
        stereo_t e;
        exp_seq = exp_map.exists(edge_n);
        e       = exp_seq ? exp_map[edge_n] : '0;
        if (sequencing === 1'b1) begin
            seq_high++;
            if (!prev_seq)
                rise_edge = edge_n;
        end
        prev_seq = sequencing;
        check($sformatf("seq@%0d", edge_n), {31'b0, sequencing}, {31'b0, exp_seq});
        if (!exp_seq || edge_n > lax_until) begin
            check($sformatf("lft@%0d", edge_n),  {16'h0, lft_out},  {16'h0, e.lft});
            check($sformatf("rght@%0d", edge_n), {16'h0, rght_out}, {16'h0, e.rght});
        end
        if (exp_seq)
            exp_map.delete(edge_n);
    endtask

    task automatic tick(input logic v, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        stereo_t s;
        valid     = v;
        lft_smpl  = l;
        rght_smpl = r;
        @(posedge clk);
        edge_n++;
        if (v && rst_n) begin
            s.lft  = l;
            s.rght = r;
            model_write(s);
        end
        if (edge_n == follow_edge)
            schedule(edge_n);
        @(negedge clk);
        valid = 1'b0;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick(1'b0, '0, '0);
    endtask

    task automatic rand_write();
        tick(1'b1, WIDTH'($urandom), WIDTH'($urandom));
    endtask

    // Fills with DEPTH-1 random samples at short random spacing; no burst may start.
    task automatic rand_fill();
        for (int i = 0; i < DEPTH - 1; i++) begin
            rand_write();
            idle($urandom_range(0, 3));
        end
    endtask

    int t0;

    initial begin
        rst_n     = 1'b0;
        valid     = 1'b0;
        lft_smpl  = '0;
        rght_smpl = '0;
        repeat (3) @(negedge clk);
        check("reset_seq",  {31'b0, sequencing}, 32'd0);
        check("reset_lft",  {16'h0, lft_out},    32'd0);
        check("reset_rght", {16'h0, rght_out},   32'd0);
        rst_n = 1'b1;

        // Ramp fill: lft=i, rght=-i; the first DEPTH-1 writes never start a burst.
        seq_high = 0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            tick(1'b1, WIDTH'(i), WIDTH'(-i));
            idle($urandom_range(0, 3));
        end
        check("no_burst_fill", 32'(seq_high), 32'd0);

        // Write that fills the buffer starts the first burst two edges later.
        tick(1'b1, WIDTH'(DEPTH - 1), WIDTH'(-(DEPTH - 1)));
        t0 = edge_n;
        idle(DEPTH + 10);
        check("burst0_len",  32'(seq_high),  32'(DEPTH));
        check("burst0_rise", 32'(rise_edge), 32'(t0 + 2));

        // Next write: oldest-first replay wraps, slot 0 holding the newest sample.
        seq_high = 0;
        tick(1'b1, WIDTH'(DEPTH), WIDTH'(-DEPTH));
        t0 = edge_n;
        idle(DEPTH + 10);
        check("burst1_len",  32'(seq_high),  32'(DEPTH));
        check("burst1_rise", 32'(rise_edge), 32'(t0 + 2));

        // Write at burst cycle 500 queues exactly one follow-up burst after a 2-cycle gap.
        seq_high = 0;
        rand_write();
        t0 = edge_n;
        idle(501);
        rand_write();
        idle(2 * DEPTH + 20);
        check("pend_len",  32'(seq_high),  32'(2 * DEPTH));
        check("pend_rise", 32'(rise_edge), 32'(t0 + DEPTH + 4));

        // Asynchronous reset at burst cycle 300 clears outputs without waiting for a clock.
        rand_write();
        idle(302);
        #2 rst_n = 1'b0;
        #1;
        check("arst_seq",  {31'b0, sequencing}, 32'd0);
        check("arst_lft",  {16'h0, lft_out},    32'd0);
        check("arst_rght", {16'h0, rght_out},   32'd0);
        model_clear();
        idle(3);
        rst_n = 1'b1;
        seq_high = 0;
        rand_fill();
        check("no_burst_refill", 32'(seq_high), 32'd0);
        rand_write();
        t0 = edge_n;
        idle(DEPTH + 10);
        check("refill_len",  32'(seq_high),  32'(DEPTH));
        check("refill_rise", 32'(rise_edge), 32'(t0 + 2));

        // Two writes two cycles apart mid-burst still yield exactly one follow-up burst.
        seq_high = 0;
        rand_write();
        idle(400);
        rand_write();
        idle(1);
        rand_write();
        idle(2 * DEPTH + 20);
        check("dbl_len", 32'(seq_high), 32'(2 * DEPTH));
        seq_high = 0;
        idle(50);
        check("dbl_idle", 32'(seq_high), 32'd0);

        // The FSM is back in IDLE and accepts a fresh trigger.
        rand_write();
        t0 = edge_n;
        idle(DEPTH + 10);
        check("final_len",  32'(seq_high),  32'(DEPTH));
        check("final_rise", 32'(rise_edge), 32'(t0 + 2));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
